out_writeback: RTL and testbench

Write-back stage directly downstream of the PE array. Captures each completed 128-bit output word (eight 16-bit psum lanes), optionally applies per-lane ReLU, and buffers words in a small FIFO. Drains the FIFO into the output global buffer through a valid/grant write port with an auto-incrementing address. One job at a time, started by the controller, with done/overflow status back to it.

---
 rtl/out_writeback_pkg.sv | 29 ++
 rtl/out_wb_fifo.sv | 57 +++++
 rtl/out_writeback.sv | 108 ++++++++++
 tb/tb_out_writeback.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/out_writeback_pkg.sv
// Shared constants, FSM encoding and the per-lane ReLU helper for out_writeback.
// The ReLU stage is enabled by defining OUT_WB_RELU_EN.
package out_writeback_pkg;

  localparam int WORD_WIDTH = 128;
  localparam int DATA_WIDTH = 16;
  localparam int LANES      = WORD_WIDTH / DATA_WIDTH;
  localparam int ADDR_WIDTH = 10;
  localparam int CNT_WIDTH  = 10;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]; negative lanes become zero.
  function automatic logic [WORD_WIDTH-1:0] relu_word(input logic [WORD_WIDTH-1:0] w);
    logic [WORD_WIDTH-1:0] r;
    r = w;
    for (int k = 0; k < LANES; k++) begin
      if (w[k*DATA_WIDTH + DATA_WIDTH - 1]) r[k*DATA_WIDTH +: DATA_WIDTH] = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/out_wb_fifo.sv
// Synchronous word FIFO with a registered head; a push while full is taken
// only when a pop happens in the same cycle.
module out_wb_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr, rd_nxt;
  logic [PW:0]      count;
  logic [WIDTH-1:0] head_q;
  logic             do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_nxt  = rd_ptr + PW'(1);
  assign head    = head_q;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_nxt;
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      // Head tracks the oldest entry; a lone entry popped while pushing hands over to the new word.
      if (do_pop && count > (PW+1)'(1))      head_q <= mem[rd_nxt];
      else if (do_pop && do_push)            head_q <= push_data;
      else if (!do_pop && do_push && empty)  head_q <= push_data;
    end
  end

endmodule

// File: rtl/out_writeback.sv
// Write-back stage: captures PE-array words, optional ReLU (OUT_WB_RELU_EN),
// buffers them and writes them to the output global buffer at incrementing addresses.
// Write port handshake: a request (gbuf_we_o with addr/data) holds stable until
// gbuf_gnt_i is high in the same cycle; that cycle transfers one word.
module out_writeback
  import out_writeback_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [CNT_WIDTH-1:0]  word_cnt_i,
  input  logic                  valid_i,
  input  logic [WORD_WIDTH-1:0] wordp_i,
  output logic                  gbuf_we_o,
  output logic [ADDR_WIDTH-1:0] gbuf_addr_o,
  output logic [WORD_WIDTH-1:0] gbuf_wdata_o,
  input  logic                  gbuf_gnt_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  ovf_o,
  output state_t                dbg_state
);
  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  acc_cnt, wr_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  ovf_q, push, pop, ovf_set, fifo_full, fifo_empty;
  logic [WORD_WIDTH-1:0] push_data;

`ifdef OUT_WB_RELU_EN
  assign push_data = relu_word(wordp_i);
`else
  assign push_data = wordp_i;
`endif

  out_wb_fifo #(.WIDTH(WORD_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (gbuf_wdata_o),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign gbuf_we_o   = !fifo_empty;
  assign gbuf_addr_o = addr_q;
  assign pop         = gbuf_we_o && gbuf_gnt_i;
  assign busy_o      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done_o      = (state_q == ST_DONE);
  assign ovf_o       = ovf_q;
  assign dbg_state   = state_q;

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    ovf_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = (word_cnt_i == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (valid_i) begin
          if (acc_cnt != '0 && (!fifo_full || pop)) push = 1'b1;
          else ovf_set = 1'b1;
        end
        if (acc_cnt == '0 || (push && acc_cnt == CNT_WIDTH'(1))) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        ovf_set = valid_i;
        // Leave as soon as the final grant lands so done follows it by one cycle.
        if (wr_cnt == '0 || (pop && wr_cnt == CNT_WIDTH'(1))) state_d = ST_DONE;
      end
      ST_DONE: begin
        ovf_set = valid_i;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      acc_cnt <= '0;
      wr_cnt  <= '0;
      addr_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start_i) begin
        addr_q  <= base_addr_i;
        acc_cnt <= word_cnt_i;
        wr_cnt  <= word_cnt_i;
        ovf_q   <= 1'b0;
      end else begin
        if (push) acc_cnt <= acc_cnt - CNT_WIDTH'(1);
        if (pop) begin
          addr_q <= addr_q + ADDR_WIDTH'(1);
          wr_cnt <= wr_cnt - CNT_WIDTH'(1);
        end
        if (ovf_set) ovf_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_out_writeback.sv
// Directed bench for out_writeback: expected writes come from a job-level model
// (address = base + n mod 1024, data = optional ReLU of the input word).
module tb_out_writeback;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [9:0]   base_addr = '0;
  logic [9:0]   word_cnt = '0;
  logic         valid = 1'b0;
  logic [127:0] wordp = '0;
  logic         gbuf_we;
  logic [9:0]   gbuf_addr;
  logic [127:0] gbuf_wdata;
  logic         gbuf_gnt = 1'b0;
  logic         busy, done, ovf;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_grant_cyc = -10;
  int n_writes = 0;
  logic [9:0]   model_addr = '0;
  logic [127:0] exp_q[$];
  logic [127:0] exp_addr_q[$];

  out_writeback dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base_addr),
    .word_cnt_i(word_cnt), .valid_i(valid), .wordp_i(wordp),
    .gbuf_we_o(gbuf_we), .gbuf_addr_o(gbuf_addr), .gbuf_wdata_o(gbuf_wdata),
    .gbuf_gnt_i(gbuf_gnt), .busy_o(busy), .done_o(done), .ovf_o(ovf),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] model_post(input logic [127:0] w);
    logic [127:0] r;
    r = w;
`ifdef OUT_WB_RELU_EN
    for (int k = 0; k < 8; k++)
      if (w[16*k+15]) r[16*k +: 16] = 16'h0000;
`endif
    return r;
  endfunction

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // scoreboard: every presented write must match the oldest expected word
  always @(negedge clk) begin
    if (!rst && gbuf_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {118'b0, gbuf_addr}, 128'hFFFF);
      end else begin
        chk("write_addr", {118'b0, gbuf_addr}, exp_addr_q[0]);
        chk("write_data", gbuf_wdata, exp_q[0]);
        if (gbuf_gnt) begin
          void'(exp_q.pop_front());
          void'(exp_addr_q.pop_front());
          n_writes++;
          last_grant_cyc = cyc;
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [9:0] b, input logic [9:0] n);
    start = 1'b1; base_addr = b; word_cnt = n;
    model_addr = b;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [127:0] w, input bit accepted);
    valid = 1'b1; wordp = w;
    if (accepted) begin
      exp_q.push_back(model_post(w));
      exp_addr_q.push_back({118'b0, model_addr});
      model_addr = model_addr + 10'd1;
    end
    tick();
    valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic exp_ovf);
    bit seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    if (!seen) begin
      chk({name, "_done_timeout"}, 128'd0, 128'd1);
    end else begin
      chk({name, "_done_after_last_grant"}, 128'(cyc - last_grant_cyc), 128'd1);
      chk({name, "_busy_in_done"}, {127'b0, busy}, 128'd0);
      chk({name, "_ovf"}, {127'b0, ovf}, {127'b0, exp_ovf});
      chk({name, "_all_written"}, 128'(exp_q.size()), 128'd0);
      @(negedge clk);
      chk({name, "_done_one_cycle"}, {127'b0, done}, 128'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [127:0] relu_in, relu_exp;
    int w0;
    bit stop_seen;

    // reset state
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_we", {127'b0, gbuf_we}, 128'd0);
    chk("reset_addr", {118'b0, gbuf_addr}, 128'd0);
    chk("reset_wdata", gbuf_wdata, 128'd0);
    chk("reset_busy", {127'b0, busy}, 128'd0);
    chk("reset_done", {127'b0, done}, 128'd0);
    chk("reset_ovf", {127'b0, ovf}, 128'd0);

    // valid in IDLE is ignored
    send_word(128'hDEAD, 0);
    tick();
    chk("idle_valid_ovf", {127'b0, ovf}, 128'd0);
    chk("idle_valid_we", {127'b0, gbuf_we}, 128'd0);

    // basic job, grant tied high
    gbuf_gnt = 1'b1;
    w0 = n_writes;
    start_job(10'h010, 10'd3);
    chk("basic_busy", {127'b0, busy}, 128'd1);
    send_word(128'h0007_0006_0005_0004_0003_0002_0001_0000, 1);
    chk("basic_first_we", {127'b0, gbuf_we}, 128'd1);
    chk("basic_first_addr", {118'b0, gbuf_addr}, 128'h010);
    chk("basic_first_data", gbuf_wdata, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    send_word(128'h1111_2222_3333_4444_5555_6666_7777_0123, 1);
    send_word(128'h0ABC_0DEF_0123_0456_0789_0001_0002_0003, 1);
    wait_done("basic", 1'b0);
    chk("basic_writes", 128'(n_writes - w0), 128'd3);

    // backpressure and overflow
    gbuf_gnt = 1'b0;
    w0 = n_writes;
    start_job(10'h100, 10'd6);
    for (int i = 0; i < 4; i++) send_word(128'(32'h0100_0000 + i), 1);
    chk("bp_no_ovf_yet", {127'b0, ovf}, 128'd0);
    send_word(128'h0555, 0);
    chk("bp_ovf_after_5th", {127'b0, ovf}, 128'd1);
    send_word(128'h0666, 0);
    tick();
    chk("bp_held_addr", {118'b0, gbuf_addr}, 128'h100);
    gbuf_gnt = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    tick();
    chk("bp_drained4", 128'(n_writes - w0), 128'd4);
    chk("bp_waiting_busy", {127'b0, busy}, 128'd1);
    chk("bp_waiting_no_done", {127'b0, done}, 128'd0);
    send_word(128'h0000_0000_0000_0000_0000_0000_0000_7777, 1);
    send_word(128'h0000_0000_0000_0000_0000_0000_0000_8888, 1);
    wait_done("bp", 1'b1);
    chk("bp_writes", 128'(n_writes - w0), 128'd6);

    // address wrap; start clears ovf
    w0 = n_writes;
    start_job(10'h3FE, 10'd4);
    chk("wrap_ovf_cleared", {127'b0, ovf}, 128'd0);
    for (int i = 0; i < 4; i++) send_word(128'($urandom_range(0, 32'h7FFF_FFFF)), 1);
    wait_done("wrap", 1'b0);
    chk("wrap_final_ptr", {118'b0, gbuf_addr}, 128'h002);
    chk("wrap_writes", 128'(n_writes - w0), 128'd4);

    // ReLU lane handling
    relu_in = {16'hFEDC, 16'h0001, 16'h8000, 16'h1234, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h8001};
`ifdef OUT_WB_RELU_EN
    relu_exp = {16'h0000, 16'h0001, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000};
`else
    relu_exp = relu_in;
`endif
    start_job(10'h020, 10'd1);
    send_word(relu_in, 1);
    chk("relu_data", gbuf_wdata, relu_exp);
    wait_done("relu", 1'b0);

    // zero-length job
    w0 = n_writes;
    start_job(10'h055, 10'd0);
    chk("zero_done", {127'b0, done}, 128'd1);
    chk("zero_busy", {127'b0, busy}, 128'd0);
    tick();
    chk("zero_done_off", {127'b0, done}, 128'd0);
    chk("zero_no_write", 128'(n_writes - w0), 128'd0);

    // start while busy is ignored; valid in DRAIN flags overflow
    gbuf_gnt = 1'b0;
    start_job(10'h040, 10'd2);
    send_word(128'hAAAA_0001, 1);
    start = 1'b1; base_addr = 10'h200; word_cnt = 10'd5;
    tick();
    start = 1'b0;
    send_word(128'hBBBB_0002, 1);
    chk("drain_no_ovf_yet", {127'b0, ovf}, 128'd0);
    send_word(128'hCCCC_0003, 0);
    chk("drain_valid_ovf", {127'b0, ovf}, 128'd1);
    gbuf_gnt = 1'b1;
    wait_done("busy_start", 1'b1);
    chk("busy_start_ptr", {118'b0, gbuf_addr}, 128'h042);

    // reset mid-job with two words parked in the FIFO
    gbuf_gnt = 1'b0;
    w0 = n_writes;
    start_job(10'h080, 10'd4);
    send_word(128'h1234_5678, 1);
    send_word(128'h9ABC_DEF0, 1);
    rst = 1'b1;
    tick();
    exp_q.delete();
    exp_addr_q.delete();
    chk("rst_we", {127'b0, gbuf_we}, 128'd0);
    chk("rst_busy", {127'b0, busy}, 128'd0);
    chk("rst_addr", {118'b0, gbuf_addr}, 128'd0);
    rst = 1'b0;
    gbuf_gnt = 1'b1;
    stop_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) stop_seen = 1;
    end
    chk("rst_no_done", {127'b0, stop_seen}, 128'd0);
    chk("rst_no_write", 128'(n_writes - w0), 128'd0);
    chk("final_queue_empty", 128'(exp_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
